iter_divider: RTL and testbench



---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 24 ++
 rtl/iter_divider.sv | 140 ++++++++++++++
 tb/tb_iter_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = $clog2(DATA_W_DEF + 1);

  // Widest operand supported; the /0 quotient is sliced down from this.
  localparam int                 MAX_W    = 64;
  localparam logic [MAX_W-1:0]   DIV0_QUO = '1;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring step: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            ge;

  assign shifted = {rem_i, quo_i[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_i};
  // A set carry-out bit always clears the divisor; otherwise diff[MSB] is the borrow.
  assign ge      = shifted[DATA_W] | ~diff[DATA_W];

  assign rem_o = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], ge};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider, stream responder returning {quotient, remainder}.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when divisor is 0 or |dividend| < |divisor|.
module iter_divider
  import div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata,
  output logic                  m_axis_dout_tvalid
);

  localparam int                CNT_LEN  = cnt_width(DATA_W);
  localparam logic [CNT_LEN-1:0] CNT_LAST = CNT_LEN'(DATA_W - 1);
  localparam logic [DATA_W-1:0] QUO_DIV0 = DIV0_QUO[DATA_W-1:0];

  div_state_e           state_q;
  logic [CNT_LEN-1:0]   cnt_q;
  logic [DATA_W-1:0]    rem_q;
  logic [DATA_W-1:0]    quo_q;
  logic [DATA_W-1:0]    dvs_q;
  logic                 q_neg_q;
  logic                 r_neg_q;
  logic                 div0_q;
  logic                 rdy_q;
  logic                 tvalid_q;
  logic [2*DATA_W-1:0]  dout_q;

  logic [DATA_W-1:0]    rem_d;
  logic [DATA_W-1:0]    quo_d;
  logic                 a_neg;
  logic                 b_neg;
  logic [DATA_W-1:0]    a_abs;
  logic [DATA_W-1:0]    b_abs;
  logic                 b_zero;
  logic                 accept;
  logic                 early_out;
  logic [DATA_W-1:0]    q_fix;
  logic [DATA_W-1:0]    r_fix;

  assign a_neg  = SIGNED & s_axis_dividend_tdata[DATA_W-1];
  assign b_neg  = SIGNED & s_axis_divisor_tdata[DATA_W-1];
  // abs(MIN) wraps back to MIN, which read as unsigned is exactly 2^(W-1).
  assign a_abs  = a_neg ? (~s_axis_dividend_tdata + 1'b1) : s_axis_dividend_tdata;
  assign b_abs  = b_neg ? (~s_axis_divisor_tdata + 1'b1) : s_axis_divisor_tdata;
  assign b_zero = (s_axis_divisor_tdata == '0);
  assign accept = rdy_q & s_axis_dividend_tvalid & s_axis_divisor_tvalid;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = b_zero | (a_abs < b_abs);
`else
  assign early_out = 1'b0;
`endif

  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // The all-ones /0 quotient must survive even when the operand signs differ.
  assign q_fix = (q_neg_q & ~div0_q) ? (~quo_q + 1'b1) : quo_q;
  assign r_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      rdy_q    <= 1'b0;
      tvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      tvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            rdy_q   <= 1'b0;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            div0_q  <= b_zero;
            dvs_q   <= b_abs;
            cnt_q   <= '0;
            if (early_out) begin
              quo_q   <= b_zero ? QUO_DIV0 : '0;
              rem_q   <= a_abs;
              state_q <= FIX;
            end else begin
              quo_q   <= a_abs;
              rem_q   <= '0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          dout_q   <= {q_fix, r_fix};
          tvalid_q <= 1'b1;
          rdy_q    <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_dividend_tready = rdy_q;
  assign s_axis_divisor_tready  = rdy_q;
  assign m_axis_dout_tdata      = dout_q;
  assign m_axis_dout_tvalid     = tvalid_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: one signed and one unsigned instance, 32-bit operands.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic [31:0] a_s = '0, b_s = '0, a_u = '0, b_u = '0;
  logic        av_s = 1'b0, bv_s = 1'b0, av_u = 1'b0, bv_u = 1'b0;
  logic        ar_s, br_s, ar_u, br_u;
  logic [63:0] d_s, d_u;
  logic        tv_s, tv_u;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_s = '0;
  logic [63:0] last_u = '0;

  localparam int LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 34;
`endif

  always #5 clk = ~clk;

  iter_divider #(.DATA_W(32), .SIGNED(1'b1)) dut_s (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_axis_dividend_tdata  (a_s),
    .s_axis_dividend_tvalid (av_s),
    .s_axis_dividend_tready (ar_s),
    .s_axis_divisor_tdata   (b_s),
    .s_axis_divisor_tvalid  (bv_s),
    .s_axis_divisor_tready  (br_s),
    .m_axis_dout_tdata      (d_s),
    .m_axis_dout_tvalid     (tv_s)
  );

  iter_divider #(.DATA_W(32), .SIGNED(1'b0)) dut_u (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_axis_dividend_tdata  (a_u),
    .s_axis_dividend_tvalid (av_u),
    .s_axis_dividend_tready (ar_u),
    .s_axis_divisor_tdata   (b_u),
    .s_axis_divisor_tvalid  (bv_u),
    .s_axis_divisor_tready  (br_u),
    .m_axis_dout_tdata      (d_u),
    .m_axis_dout_tvalid     (tv_u)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present both operands, take the accept edge, then confirm the previous result is held.
  task automatic start(input bit u, input logic [31:0] a, input logic [31:0] b, input string tag);
    if (u) begin
      a_u = a; b_u = b; av_u = 1'b1; bv_u = 1'b1;
      chk({tag, "_rdy"}, {62'b0, ar_u, br_u}, 64'h3);
    end else begin
      a_s = a; b_s = b; av_s = 1'b1; bv_s = 1'b1;
      chk({tag, "_rdy"}, {62'b0, ar_s, br_s}, 64'h3);
    end
    @(posedge clk); #1;
    av_s = 1'b0; bv_s = 1'b0; av_u = 1'b0; bv_u = 1'b0;
    chk({tag, "_pulse"}, 64'(u ? tv_u : tv_s), 64'h0);
    chk({tag, "_hold"}, u ? d_u : d_s, u ? last_u : last_s);
  endtask

  // Latency counts the accept cycle as cycle 1; returns #1 after the tvalid edge.
  task automatic finish_op(input bit u, input logic [63:0] exp, input int exp_lat, input string tag);
    int lat;
    bit busy_rdy;
    lat = 1;
    busy_rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (u ? tv_u : tv_s) break;
      if (u ? ar_u : ar_s) busy_rdy = 1'b1;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, u ? d_u : d_s, exp);
    chk({tag, "_busy"}, 64'(busy_rdy), 64'h0);
    chk({tag, "_rdy_on_valid"}, 64'(u ? ar_u : ar_s), 64'h1);
    if (u) last_u = exp;
    else   last_s = exp;
  endtask

  initial begin
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy_s", {62'b0, ar_s, br_s}, 64'h0);
    chk("rst_rdy_u", {62'b0, ar_u, br_u}, 64'h0);
    chk("rst_valid", {62'b0, tv_s, tv_u}, 64'h0);
    chk("rst_data_s", d_s, 64'h0);
    chk("rst_data_u", d_u, 64'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy_s", 64'(ar_s), 64'h1);

    start(1'b0, 32'd100, 32'd7, "s_100_7");
    finish_op(1'b0, {32'h0000000E, 32'h00000002}, LAT, "s_100_7");
    // Back-to-back: next request issued in the tvalid cycle.
    start(1'b0, 32'hFFFFFFF9, 32'd2, "s_m7_2");
    finish_op(1'b0, {32'hFFFFFFFD, 32'hFFFFFFFF}, LAT, "s_m7_2");
    start(1'b0, 32'h80000000, 32'hFFFFFFFF, "s_min_m1");
    finish_op(1'b0, {32'h80000000, 32'h00000000}, LAT, "s_min_m1");
    start(1'b0, 32'hFFFFFF9C, 32'd7, "s_m100_7");
    finish_op(1'b0, {32'hFFFFFFF2, 32'hFFFFFFFE}, LAT, "s_m100_7");
    start(1'b0, 32'd100, 32'hFFFFFFF9, "s_100_m7");
    finish_op(1'b0, {32'hFFFFFFF2, 32'h00000002}, LAT, "s_100_m7");
    start(1'b0, 32'hFFFFFFFB, 32'd0, "s_m5_0");
    finish_op(1'b0, {32'hFFFFFFFF, 32'hFFFFFFFB}, EO_LAT, "s_m5_0");
    start(1'b0, 32'hFFFFFFFD, 32'd10, "s_m3_10");
    finish_op(1'b0, {32'h00000000, 32'hFFFFFFFD}, EO_LAT, "s_m3_10");
    start(1'b0, 32'd3, 32'd10, "s_3_10");
    finish_op(1'b0, {32'h00000000, 32'h00000003}, EO_LAT, "s_3_10");
    start(1'b0, 32'd20, 32'd3, "s_20_3");
    finish_op(1'b0, {32'h00000006, 32'h00000002}, LAT, "s_20_3");

    start(1'b1, 32'hFFFFFFFF, 32'h10, "u_max_16");
    finish_op(1'b1, {32'h0FFFFFFF, 32'h0000000F}, LAT, "u_max_16");
    start(1'b1, 32'd5, 32'd0, "u_5_0");
    finish_op(1'b1, {32'hFFFFFFFF, 32'h00000005}, EO_LAT, "u_5_0");
    start(1'b1, 32'h80000000, 32'hFFFFFFFF, "u_big_small");
    finish_op(1'b1, {32'h00000000, 32'h80000000}, EO_LAT, "u_big_small");
    start(1'b1, 32'd7, 32'd7, "u_7_7");
    finish_op(1'b1, {32'h00000001, 32'h00000000}, LAT, "u_7_7");

    // Only the dividend channel valid: nothing may be consumed.
    @(posedge clk); #1;
    a_s = 32'd1000; b_s = 32'd7; av_s = 1'b1; bv_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("partial_rdy_hold", {62'b0, ar_s, tv_s}, 64'h2);
    end
    bv_s = 1'b1;
    @(posedge clk); #1;
    av_s = 1'b0; bv_s = 1'b0;
    finish_op(1'b0, {32'h0000008E, 32'h00000006}, LAT, "s_joint");

    // Reset in the middle of CALC aborts the operation.
    start(1'b0, 32'd1000, 32'd7, "s_abort");
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", 64'(tv_s), 64'h0);
    chk("abort_data", d_s, 64'h0);
    chk("abort_rdy", 64'(ar_s), 64'h0);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (tv_s) seen = 1'b1;
    end
    chk("abort_no_pulse", 64'(seen), 64'h0);
    last_s = '0;
    last_u = '0;
    start(1'b0, 32'd9, 32'd3, "s_9_3");
    finish_op(1'b0, {32'h00000003, 32'h00000000}, LAT, "s_9_3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
